// File: rtl/beat_tone_gen.sv
// beat_tone_gen: 16-note square-wave melody player; the note is picked by ibeat[5:2].
// Define STEREO_OCTAVE_EN for an independent right channel one octave lower; otherwise audio_right mirrors audio_left.
module beat_tone_gen #(
  parameter int unsigned HALF_NUM = 50_000_000  // clk cycles in half a second
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] ibeat,
  input  logic        en,
  input  logic [2:0]  volume,
  output logic [15:0] audio_left,
  output logic [15:0] audio_right,
  output logic        beat_strobe,
  output logic        note_valid
);

  typedef logic [21:0] half_t;

  // Half-period in clk cycles for each melody step; 0 marks the rest.
  localparam half_t HALF_TBL [16] = '{
    half_t'(HALF_NUM / 262), half_t'(HALF_NUM / 294), half_t'(HALF_NUM / 330), half_t'(HALF_NUM / 349),
    half_t'(HALF_NUM / 392), half_t'(HALF_NUM / 440), half_t'(HALF_NUM / 494), half_t'(HALF_NUM / 523),
    half_t'(HALF_NUM / 523), half_t'(HALF_NUM / 494), half_t'(HALF_NUM / 440), half_t'(HALF_NUM / 392),
    half_t'(HALF_NUM / 349), half_t'(HALF_NUM / 330), half_t'(HALF_NUM / 294), half_t'(0)
  };

  logic [11:0] ibeat_q;
  logic [15:0] amp;
  half_t       target_left;
  half_t       active_left;
  half_t       count_left;
  logic        phase_left;

  assign target_left = HALF_TBL[ibeat[5:2]];

  always_comb begin
    amp = 16'h0000;
    if (volume != 3'd0) amp = 16'h0100 << (volume - 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibeat_q     <= '0;
      beat_strobe <= 1'b0;
      note_valid  <= 1'b0;
    end else begin
      ibeat_q     <= ibeat;
      beat_strobe <= (ibeat != ibeat_q);
      note_valid  <= (active_left != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_left <= '0;
      count_left  <= '0;
      phase_left  <= 1'b0;
      audio_left  <= '0;
    end else begin
      // NOTE: non-blocking updates make the sample below see the pre-edge phase, giving one cycle of output latency.
      audio_left <= (en && active_left != '0) ? (phase_left ? amp : -amp) : '0;
      if (!en || active_left == '0) begin
        active_left <= target_left;
        count_left  <= '0;
        phase_left  <= 1'b0;
      end else if (count_left == active_left - half_t'(1)) begin
        // A new note is adopted only at a phase edge, so no half-period is cut short.
        active_left <= target_left;
        count_left  <= '0;
        phase_left  <= ~phase_left;
      end else begin
        count_left <= count_left + half_t'(1);
      end
    end
  end

`ifdef STEREO_OCTAVE_EN
  half_t target_right;
  half_t active_right;
  half_t count_right;
  logic  phase_right;

  assign target_right = {target_left[20:0], 1'b0};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_right <= '0;
      count_right  <= '0;
      phase_right  <= 1'b0;
      audio_right  <= '0;
    end else begin
      audio_right <= (en && active_right != '0) ? (phase_right ? amp : -amp) : '0;
      if (!en || active_right == '0) begin
        active_right <= target_right;
        count_right  <= '0;
        phase_right  <= 1'b0;
      end else if (count_right == active_right - half_t'(1)) begin
        active_right <= target_right;
        count_right  <= '0;
        phase_right  <= ~phase_right;
      end else begin
        count_right <= count_right + half_t'(1);
      end
    end
  end
`else
  assign audio_right = audio_left;
`endif

endmodule
